tcm_dual_port: RTL and testbench

- Parametrised dual-port tightly-coupled memory for instruction fetch and load/store; next generation of the fixed 32-bit byte-banked main memory.
- Storage is DATA_W/8 byte lanes with arbitrary per-byte write enables.
- Each port has its own programmable wait-state FSM and req/ack handshake.
- Out-of-range accesses return an error response.

---
 rtl/tcm_dual_port.sv | 171 +++++++++++++++++
 tb/tb_tcm_dual_port.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_dual_port.sv
// Dual-port tightly-coupled memory: instruction fetch port and load/store port, each with a wait-state FSM.
// Optional build macro TCM_WRITE_FORWARD_EN forwards a same-edge store into the colliding instruction read.
module tcm_dual_port #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] INSTR_NOP   = DATA_W'(32'h00000013)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_ack_o,
  output logic                i_err_o,
  input  logic                d_req_i,
  input  logic                d_sel_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,
  output logic                d_err_o
);
  localparam int NB = DATA_W / 8;
  localparam int LG = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW = ADDR_W - LG;
  localparam int MW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Handshake: a port accepts when req is high at a rising edge while it is IDLE or RESP;
  // ack is high for exactly the RESP cycle, err/rdata are valid only alongside ack.
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef struct packed {
    state_e     i_state;
    logic [3:0] i_cnt;
    state_e     d_state;
    logic [3:0] d_cnt;
  } fsm_dbg_t;

  state_e i_state_q, i_state_d, d_state_q, d_state_d;
  logic [3:0] i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  fsm_dbg_t fsm_dbg;
  assign fsm_dbg = '{i_state_q, i_cnt_q, d_state_q, d_cnt_q};

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [ADDR_W-1:0] i_addr_q, d_addr_q;
  logic              d_we_q;
  logic [NB-1:0]     d_be_q;
  logic [DATA_W-1:0] d_wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_err_q, d_err_q;

  logic i_acc, d_acc, i_fire, d_fire;
  assign i_acc = i_req_i && (i_state_q != ST_WAIT);
  assign d_acc = d_req_i && d_sel_i && (d_state_q != ST_WAIT);

  // With no wait states the access edge is the accept edge, so live inputs stand in for the captured ones.
  logic [ADDR_W-1:0] i_addr_a, d_addr_a;
  logic              d_we_a;
  logic [NB-1:0]     d_be_a;
  logic [DATA_W-1:0] d_wdata_a;
  assign i_addr_a  = (WAIT_STATES == 0) ? i_addr_i  : i_addr_q;
  assign d_addr_a  = (WAIT_STATES == 0) ? d_addr_i  : d_addr_q;
  assign d_we_a    = (WAIT_STATES == 0) ? d_we_i    : d_we_q;
  assign d_be_a    = (WAIT_STATES == 0) ? d_be_i    : d_be_q;
  assign d_wdata_a = (WAIT_STATES == 0) ? d_wdata_i : d_wdata_q;

  logic [IW-1:0] i_idx, d_idx;
  logic [MW-1:0] i_midx, d_midx;
  logic          i_in, d_in;
  assign i_idx  = i_addr_a[ADDR_W-1:LG];
  assign d_idx  = d_addr_a[ADDR_W-1:LG];
  assign i_midx = i_idx[MW-1:0];
  assign d_midx = d_idx[MW-1:0];
  assign i_in   = 64'(i_idx) < 64'(DEPTH_WORDS);
  assign d_in   = 64'(d_idx) < 64'(DEPTH_WORDS);

  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    case (i_state_q)
      ST_WAIT: if (i_cnt_q == 4'd0) i_state_d = ST_RESP; else i_cnt_d = i_cnt_q - 4'd1;
      default: if (i_acc) begin
        i_state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        i_cnt_d   = WS_M1;
      end else i_state_d = ST_IDLE;
    endcase
    case (d_state_q)
      ST_WAIT: if (d_cnt_q == 4'd0) d_state_d = ST_RESP; else d_cnt_d = d_cnt_q - 4'd1;
      default: if (d_acc) begin
        d_state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        d_cnt_d   = WS_M1;
      end else d_state_d = ST_IDLE;
    endcase
  end

  assign i_fire = (i_state_d == ST_RESP);
  assign d_fire = (d_state_d == ST_RESP);

  logic [DATA_W-1:0] i_word;
`ifdef TCM_WRITE_FORWARD_EN
  logic coll;
  assign coll = d_fire && d_we_a && d_in && i_in && (i_idx == d_idx);
  always_comb begin
    i_word = mem_q[i_midx];
    for (int k = 0; k < NB; k++)
      if (coll && d_be_a[k]) i_word[8*k +: 8] = d_wdata_a[8*k +: 8];
  end
`else
  assign i_word = mem_q[i_midx];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_state_q <= ST_IDLE;
      d_state_q <= ST_IDLE;
      i_cnt_q   <= 4'd0;
      d_cnt_q   <= 4'd0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      i_state_q <= i_state_d;
      d_state_q <= d_state_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      if (i_fire) begin
        i_err_q   <= !i_in;
        i_rdata_q <= i_in ? i_word : '0;
      end
      if (d_fire) begin
        d_err_q <= !d_in;
        if (!d_we_a) d_rdata_q <= d_in ? mem_q[d_midx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_acc) i_addr_q <= i_addr_i;
    if (d_acc) begin
      d_addr_q  <= d_addr_i;
      d_we_q    <= d_we_i;
      d_be_q    <= d_be_i;
      d_wdata_q <= d_wdata_i;
    end
  end

  // Storage is not reset; reset only suppresses a store that would land on the reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && d_fire && d_we_a && d_in)
      for (int k = 0; k < NB; k++)
        if (d_be_a[k]) mem_q[d_midx][8*k +: 8] <= d_wdata_a[8*k +: 8];
  end

  assign i_ack_o   = (i_state_q == ST_RESP);
  assign i_err_o   = i_ack_o && i_err_q;
  assign i_rdata_o = i_ack_o ? i_rdata_q : INSTR_NOP;
  assign d_ack_o   = (d_state_q == ST_RESP);
  assign d_err_o   = d_ack_o && d_err_q;
  assign d_rdata_o = d_rdata_q;

  logic unused_bits;
  assign unused_bits = ^{i_addr_i, d_addr_i, i_addr_q, d_addr_q, d_we_q, d_be_q, d_wdata_q, fsm_dbg};
endmodule

// File: tb/tb_tcm_dual_port.sv
// Bench for tcm_dual_port: two instances (0 and 3 wait states) driven with shared stimulus and
// checked every cycle against a transaction-timing reference model, plus directed scenario checks.
module tb_tcm_dual_port;
  localparam int          DEPTH = 1000;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef TCM_WRITE_FORWARD_EN
  localparam logic [31:0] COLL_EXP = 32'h12345655;
`else
  localparam logic [31:0] COLL_EXP = 32'h12345678;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_sel, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata [2];
  logic [31:0] d_rdata [2];
  logic        i_ack [2];
  logic        i_err [2];
  logic        d_ack [2];
  logic        d_err [2];

  always #5 clk = ~clk;

  tcm_dual_port #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata[0]), .i_ack_o(i_ack[0]), .i_err_o(i_err[0]),
    .d_req_i(d_req), .d_sel_i(d_sel), .d_we_i(d_we), .d_addr_i(d_addr), .d_be_i(d_be),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata[0]), .d_ack_o(d_ack[0]), .d_err_o(d_err[0]));

  tcm_dual_port #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata[1]), .i_ack_o(i_ack[1]), .i_err_o(i_err[1]),
    .d_req_i(d_req), .d_sel_i(d_sel), .d_we_i(d_we), .d_addr_i(d_addr), .d_be_i(d_be),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata[1]), .d_ack_o(d_ack[1]), .d_err_o(d_err[1]));

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic        v;
    int          due;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  txn_t        pend_i [2];
  txn_t        pend_d [2];
  int          i_free [2];
  int          d_free [2];
  logic [31:0] ref_mem [2][16];
  logic [31:0] exp_q [$];
  logic        e_i_ack [2];
  logic        e_i_err [2];
  logic        e_d_ack [2];
  logic        e_d_err [2];
  logic [31:0] e_i_rdata [2];
  logic [31:0] e_d_rdata [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int word_index(input logic [31:0] a);
    return int'(a >> 2);
  endfunction

  // One rising edge of the model for instance k: accept rules come from the timing arithmetic
  // (a port can take a new request WS+1 edges after the previous accept), the response lands WS edges later.
  task automatic model_edge(input int k);
    int          ws, iidx, didx;
    logic        ir, dr;
    logic [31:0] iw, nw;
    ws = (k == 0) ? WS0 : WS1;
    if (!rst_n) begin
      pend_i[k].v = 1'b0;  pend_d[k].v = 1'b0;
      i_free[k]   = cyc + 1; d_free[k] = cyc + 1;
      e_i_ack[k]  = 1'b0;  e_i_err[k] = 1'b0;  e_i_rdata[k] = NOP;
      e_d_ack[k]  = 1'b0;  e_d_err[k] = 1'b0;  e_d_rdata[k] = 32'h0;
      return;
    end
    if (i_req && cyc >= i_free[k]) begin
      pend_i[k] = '{1'b1, cyc + ws, i_addr, 1'b0, 4'h0, 32'h0};
      i_free[k] = cyc + ws + 1;
    end
    if (d_req && d_sel && cyc >= d_free[k]) begin
      pend_d[k] = '{1'b1, cyc + ws, d_addr, d_we, d_be, d_wdata};
      d_free[k] = cyc + ws + 1;
    end
    e_i_ack[k] = 1'b0; e_i_err[k] = 1'b0; e_i_rdata[k] = NOP;
    e_d_ack[k] = 1'b0; e_d_err[k] = 1'b0;
    ir   = pend_i[k].v && (pend_i[k].due == cyc);
    dr   = pend_d[k].v && (pend_d[k].due == cyc);
    iidx = word_index(pend_i[k].addr);
    didx = word_index(pend_d[k].addr);
    iw   = 32'h0;
    if (ir) begin
      pend_i[k].v = 1'b0;
      e_i_ack[k]  = 1'b1;
      e_i_err[k]  = (iidx >= DEPTH);
      if (iidx < DEPTH) iw = ref_mem[k][iidx];
    end
    if (dr) begin
      pend_d[k].v = 1'b0;
      e_d_ack[k]  = 1'b1;
      e_d_err[k]  = (didx >= DEPTH);
      if (!pend_d[k].we) e_d_rdata[k] = (didx < DEPTH) ? ref_mem[k][didx] : 32'h0;
      else if (didx < DEPTH) begin
        nw = ref_mem[k][didx];
        for (int b = 0; b < 4; b++)
          if (pend_d[k].be[b]) nw[8*b +: 8] = pend_d[k].wdata[8*b +: 8];
`ifdef TCM_WRITE_FORWARD_EN
        if (ir && iidx == didx) iw = nw;
`endif
        ref_mem[k][didx] = nw;
      end
    end
    if (ir) e_i_rdata[k] = iw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(e_i_rdata[k]);
      exp_q.push_back(e_d_rdata[k]);
      check($sformatf("i_ack[%0d]", k), 32'(i_ack[k]), 32'(e_i_ack[k]));
      check($sformatf("i_err[%0d]", k), 32'(i_err[k]), 32'(e_i_err[k]));
      check($sformatf("d_ack[%0d]", k), 32'(d_ack[k]), 32'(e_d_ack[k]));
      check($sformatf("d_err[%0d]", k), 32'(d_err[k]), 32'(e_d_err[k]));
      check($sformatf("i_rdata[%0d]", k), i_rdata[k], exp_q.pop_front());
      check($sformatf("d_rdata[%0d]", k), d_rdata[k], exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_addr();
    int unsigned idx;
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 3))
        0:       idx = 1000;
        1:       idx = 1023;
        2:       idx = 1024;
        default: idx = 32'h3FFFFFFF;
      endcase
    end else idx = $urandom_range(0, 15);
    return {idx[29:0], 2'($urandom_range(0, 3))};
  endfunction

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    d_req = 1'b1; d_sel = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wd;
    step();
    d_req = 1'($urandom_range(0, 1)); d_sel = 1'b0; d_we = 1'($urandom_range(0, 1));
    d_addr = $urandom(); d_be = 4'($urandom()); d_wdata = $urandom();
    repeat (WS1 + 1) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses [2];
    rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_sel = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h0; d_wdata = 32'h0;
    @(negedge clk);
    repeat (3) step();
    check("rst_i_rdata", i_rdata[1], NOP);
    check("rst_d_rdata", d_rdata[1], 32'h0);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) d_txn(1'b1, 32'(w * 4), 4'hF, $urandom());

    // store then load at 0x10, latency per instance
    d_req = 1'b1; d_sel = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_be = 4'hF; d_wdata = 32'hDEADBEEF;
    step();
    check("lat_ws0", 32'(d_ack[0]), 32'd1);
    check("lat_ws3_early", 32'(d_ack[1]), 32'd0);
    d_req = 1'b0; d_wdata = 32'h0; d_addr = 32'h0;
    repeat (3) step();
    check("lat_ws3", 32'(d_ack[1]), 32'd1);
    repeat (2) step();
    d_txn(1'b0, 32'h10, 4'h0, 32'h0);
    check("ld_deadbeef0", d_rdata[0], 32'hDEADBEEF);
    check("ld_deadbeef1", d_rdata[1], 32'hDEADBEEF);

    // partial byte enables and the empty-mask store
    d_txn(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA);
    d_txn(1'b1, 32'h20, 4'b0101, 32'h11223344);
    d_txn(1'b0, 32'h20, 4'h0, 32'h0);
    check("be_merge0", d_rdata[0], 32'hAA22AA44);
    check("be_merge1", d_rdata[1], 32'hAA22AA44);
    d_txn(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
    d_txn(1'b0, 32'h22, 4'h0, 32'h0);
    check("be_zero", d_rdata[1], 32'hAA22AA44);

    // held fetch: one ack per WS+1 cycles
    pulses = '{0, 0};
    i_req = 1'b1; i_addr = 32'h0;
    for (int c = 0; c < 16; c++) begin
      step();
      for (int k = 0; k < 2; k++) pulses[k] += int'(i_ack[k]);
    end
    i_req = 1'b0;
    repeat (4) step();
    check("fetch_pulses0", 32'(pulses[0]), 32'd16);
    check("fetch_pulses1", 32'(pulses[1]), 32'd4);

    // out-of-range and index aliasing
    d_txn(1'b1, 32'h0, 4'hF, 32'h01020304);
    d_txn(1'b0, 32'hFA0, 4'h0, 32'h0);
    check("oor_rdata", d_rdata[0], 32'h0);
    d_txn(1'b1, 32'hFA0, 4'hF, 32'hFFFFFFFF);
    d_txn(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    d_txn(1'b0, 32'h0, 4'h0, 32'h0);
    check("alias0", d_rdata[0], 32'h01020304);
    check("alias1", d_rdata[1], 32'h01020304);

    // same-edge store and fetch of one word
    d_txn(1'b1, 32'h18, 4'hF, 32'h12345678);
    i_req = 1'b1; i_addr = 32'h18;
    d_req = 1'b1; d_sel = 1'b1; d_we = 1'b1; d_addr = 32'h18; d_be = 4'b0001; d_wdata = 32'h00000055;
    step();
    check("coll0", i_rdata[0], COLL_EXP);
    i_req = 1'b0; d_req = 1'b0; i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) step();
    check("coll1", i_rdata[1], COLL_EXP);
    repeat (2) step();
    d_txn(1'b0, 32'h18, 4'h0, 32'h0);
    check("coll_store1", d_rdata[1], 32'h12345655);

    // reset while a store waits
    d_txn(1'b1, 32'h14, 4'hF, 32'h0BADF00D);
    d_req = 1'b1; d_sel = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_be = 4'hF; d_wdata = 32'hCAFEF00D;
    step();
    d_req = 1'b0;
    rst_n = 1'b0;
    step();
    check("rstw_i_rdata", i_rdata[1], NOP);
    check("rstw_d_rdata", d_rdata[1], 32'h0);
    rst_n = 1'b1;
    repeat (4) step();
    d_txn(1'b0, 32'h14, 4'h0, 32'h0);
    check("rstw_mem1", d_rdata[1], 32'h0BADF00D);
    check("rstw_mem0", d_rdata[0], 32'hCAFEF00D);

    // randomized traffic, both ports, occasional reset
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      i_req   = 1'($urandom_range(0, 1));
      i_addr  = rand_addr();
      d_req   = 1'($urandom_range(0, 1));
      d_sel   = ($urandom_range(0, 3) != 0);
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = ($urandom_range(0, 3) == 0) ? i_addr : rand_addr();
      d_be    = 4'($urandom());
      d_wdata = $urandom();
      step();
    end
    rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
